// File: rtl/systolic_out_collector_pkg.sv
// Shared types for the systolic output collector: FSM state encoding and default lane FIFO depth.
package systolic_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    COLLECT = ST_COLLECT_ENC,
    DRAIN   = ST_DRAIN_ENC
  } coll_state_e;

  localparam int COLLECT_DEPTH = 8;

endpackage

// File: rtl/systolic_out_collector_if.sv
// Collector bus: skewed per-column results in, aligned row vectors out (valid/ready) plus job status.
interface systolic_out_collector_if #(
  parameter int width = 8,
  parameter int col   = 3
);

  logic [width-1:0] systolic_out [col-1:0];
  logic [col-1:0]   out_en;
  logic             conv_finish;
  logic [width-1:0] row_data [col-1:0];
  logic             row_valid;
  logic             row_ready;
  logic             collect_busy;
  logic             overflow;
  logic             misalign;
  logic             drain_done;

  // master: the side that feeds results and consumes rows; slave: the collector itself
  modport master (
    output systolic_out, out_en, conv_finish, row_ready,
    input  row_data, row_valid, collect_busy, overflow, misalign, drain_done
  );

  modport slave (
    input  systolic_out, out_en, conv_finish, row_ready,
    output row_data, row_valid, collect_busy, overflow, misalign, drain_done
  );

endinterface

// File: rtl/systolic_out_collector_col_fifo.sv
// Single-clock lane FIFO, one-cycle write-to-head latency; the caller must not push when full unless popping.
// Memory is cleared on reset so the head reads zero from reset; flush only rewinds the pointers.
module col_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [width-1:0] din,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // push and pop together leave the occupancy unchanged
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/systolic_out_collector.sv
// Re-aligns diagonally skewed column results into full rows; a row appears one cycle after its last column push.
// Rows are held while row_ready is low; a push into a full lane without a same-cycle pop is dropped and flagged.
module systolic_out_collector
  import systolic_pkg::*;
#(
  parameter int width = 8,
  parameter int col   = 3,
  parameter int depth = COLLECT_DEPTH
) (
  input logic                      clk,
  input logic                      nrst,
  systolic_out_collector_if.slave  bus
);

  coll_state_e state;
  coll_state_e state_nxt;

  logic [col-1:0]   full;
  logic [col-1:0]   empty;
  logic [col-1:0]   push;
  logic [width-1:0] head [col-1:0];

  logic row_valid;
  logic pop_all;
  logic any_en;
  logic all_empty;
  logic any_empty;
  logic flush;
  logic leave_idle;
  logic ovf_set;
  logic overflow_q;
  logic misalign_q;

  assign row_valid = ~|empty;
  assign pop_all   = row_valid & bus.row_ready;
  assign any_en    = |bus.out_en;
  assign all_empty = &empty;
  assign any_empty = |empty;

  // Lanes disagree at the end of a job and nothing more is arriving: discard the leftovers
  assign flush = (state == DRAIN) && any_empty && !all_empty && !any_en;

  assign push    = bus.out_en & (~full | {col{pop_all}}) & ~{col{flush}};
  assign ovf_set = |(bus.out_en & full & ~{col{pop_all}});

  assign leave_idle = (state == IDLE) && (any_en || bus.conv_finish);

  genvar c;
  generate
    for (c = 0; c < col; c++) begin : g_lane
      col_fifo #(
        .width (width),
        .depth (depth)
      ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push[c]),
        .pop   (pop_all),
        .flush (flush),
        .din   (bus.systolic_out[c]),
        .head  (head[c]),
        .full  (full[c]),
        .empty (empty[c])
      );

      assign bus.row_data[c] = head[c];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_en) begin
          state_nxt = COLLECT;
        end else if (bus.conv_finish) begin
          state_nxt = DRAIN;
        end
      end
      COLLECT: begin
        if (bus.conv_finish) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (all_empty || flush) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      // a new job clears the sticky flags, but an event in the same cycle still lands
      overflow_q <= (overflow_q & ~leave_idle) | ovf_set;
      misalign_q <= (misalign_q & ~leave_idle) | flush;
    end
  end

  assign bus.row_valid    = row_valid;
  assign bus.collect_busy = (state != IDLE);
  assign bus.overflow     = overflow_q;
  assign bus.misalign     = misalign_q;
  assign bus.drain_done   = (state == DRAIN) && (all_empty || flush);

endmodule

// File: tb/tb_systolic_out_collector.sv
// Directed bench for the collector: alignment, skew, backpressure, drain, misalign and async reset.
module tb_systolic_out_collector;

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  systolic_out_collector_if #(.width(8), .col(3)) bus ();

  systolic_out_collector #(.width(8), .col(3), .depth(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] en, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.out_en          = en;
    bus.systolic_out[0] = d0;
    bus.systolic_out[1] = d1;
    bus.systolic_out[2] = d2;
  endtask

  // Pulses conv_finish with row_ready high and reports whether drain_done arrived in time
  task automatic finish_job(output bit ok);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    bus.conv_finish = 1'b1;
    bus.row_ready   = 1'b1;
    @(negedge clk);
    bus.conv_finish = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (bus.drain_done === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    bus.row_ready   = 1'b0;
    bus.conv_finish = 1'b0;
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    #2;
    checks++;
    if ({bus.row_valid, bus.collect_busy, bus.overflow, bus.misalign, bus.drain_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.row_valid, bus.collect_busy, bus.overflow, bus.misalign, bus.drain_done});
    end
    checks++;
    if (bus.row_data[0] !== 8'd0 || bus.row_data[1] !== 8'd0 || bus.row_data[2] !== 8'd0) begin
      errors++;
      $display("FAIL reset_row_data: got (%0d,%0d,%0d) expected (0,0,0)",
               bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_aligned();
    bit ok;
    logic [7:0] exp_rows [3][3];
    exp_rows = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
    @(negedge clk);
    bus.row_ready = 1'b1;
    drive(3'b111, 8'd1, 8'd2, 8'd3);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.collect_busy !== 1'b0) begin
      errors++;
      $display("FAIL aligned_pre: got valid=%b busy=%b expected valid=0 busy=0", bus.row_valid, bus.collect_busy);
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if (r < 2) drive(3'b111, exp_rows[r+1][0], exp_rows[r+1][1], exp_rows[r+1][2]);
      else       drive(3'b000, 8'd0, 8'd0, 8'd0);
      #1;
      checks++;
      if (bus.row_valid !== 1'b1 || bus.collect_busy !== 1'b1 || bus.row_data[0] !== exp_rows[r][0] ||
          bus.row_data[1] !== exp_rows[r][1] || bus.row_data[2] !== exp_rows[r][2]) begin
        errors++;
        $display("FAIL aligned_row%0d: got v=%b busy=%b (%0d,%0d,%0d) expected v=1 busy=1 (%0d,%0d,%0d)", r,
                 bus.row_valid, bus.collect_busy, bus.row_data[0], bus.row_data[1], bus.row_data[2],
                 exp_rows[r][0], exp_rows[r][1], exp_rows[r][2]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL aligned_post: got valid=%b ovf=%b expected valid=0 ovf=0", bus.row_valid, bus.overflow);
    end
    finish_job(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL aligned_done: got no drain_done expected drain_done pulse");
    end
  endtask

  task automatic test_skewed();
    bit ok;
    logic [2:0] ens [3];
    ens = '{3'b001, 3'b010, 3'b100};
    bus.row_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive(ens[t], 8'd10, 8'd20, 8'd30);
      #1;
      checks++;
      if (bus.row_valid !== 1'b0) begin
        errors++;
        $display("FAIL skew_t%0d_valid: got %b expected 0", t, bus.row_valid);
      end
    end
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    #1;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.row_data[0] !== 8'd10 || bus.row_data[1] !== 8'd20 || bus.row_data[2] !== 8'd30) begin
      errors++;
      $display("FAIL skew_t3_row: got v=%b (%0d,%0d,%0d) expected v=1 (10,20,30)",
               bus.row_valid, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL skew_t4_valid: got %b expected 0", bus.row_valid);
    end
    finish_job(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL skew_done: got no drain_done expected drain_done pulse");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] k8;
    bus.row_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      k8 = 8'(k);
      drive(3'b111, k8, k8 + 8'd10, k8 + 8'd20);
      if (k == 9) begin
        #1;
        checks++;
        if (bus.overflow !== 1'b0) begin
          errors++;
          $display("FAIL bp_ovf_before: got %b expected 0", bus.overflow);
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      drive(3'b000, 8'd0, 8'd0, 8'd0);
      #1;
      checks++;
      if (bus.overflow !== 1'b1 || bus.row_valid !== 1'b1 || bus.row_data[0] !== 8'd1 ||
          bus.row_data[1] !== 8'd11 || bus.row_data[2] !== 8'd21) begin
        errors++;
        $display("FAIL bp_stall%0d: got ovf=%b v=%b (%0d,%0d,%0d) expected ovf=1 v=1 (1,11,21)", s,
                 bus.overflow, bus.row_valid, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.row_ready = 1'b1;
      k8 = 8'(k);
      #1;
      checks++;
      if (bus.row_valid !== 1'b1 || bus.row_data[0] !== k8 || bus.row_data[1] !== k8 + 8'd10 ||
          bus.row_data[2] !== k8 + 8'd20) begin
        errors++;
        $display("FAIL bp_row%0d: got v=%b (%0d,%0d,%0d) expected v=1 (%0d,%0d,%0d)", k, bus.row_valid,
                 bus.row_data[0], bus.row_data[1], bus.row_data[2], k8, k8 + 8'd10, k8 + 8'd20);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_ninth_dropped: got valid=%b expected 0", bus.row_valid);
    end
    finish_job(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_done: got no drain_done expected drain_done pulse");
    end
  endtask

  task automatic test_drain();
    bus.row_ready = 1'b0;
    @(negedge clk);
    drive(3'b111, 8'd1, 8'd2, 8'd3);
    @(negedge clk);
    drive(3'b111, 8'd4, 8'd5, 8'd6);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    bus.conv_finish = 1'b1;
    bus.row_ready   = 1'b1;
    #1;
    checks++;
    if (bus.overflow !== 1'b0 || bus.collect_busy !== 1'b1 || bus.row_valid !== 1'b1 ||
        bus.row_data[0] !== 8'd1 || bus.row_data[1] !== 8'd2 || bus.row_data[2] !== 8'd3) begin
      errors++;
      $display("FAIL drain_row0: got ovf=%b busy=%b v=%b (%0d,%0d,%0d) expected ovf=0 busy=1 v=1 (1,2,3)",
               bus.overflow, bus.collect_busy, bus.row_valid, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    bus.conv_finish = 1'b0;
    #1;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.drain_done !== 1'b0 || bus.row_data[0] !== 8'd4 ||
        bus.row_data[1] !== 8'd5 || bus.row_data[2] !== 8'd6) begin
      errors++;
      $display("FAIL drain_row1: got v=%b done=%b (%0d,%0d,%0d) expected v=1 done=0 (4,5,6)",
               bus.row_valid, bus.drain_done, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.drain_done !== 1'b1 || bus.collect_busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_pulse: got v=%b done=%b busy=%b expected v=0 done=1 busy=1",
               bus.row_valid, bus.drain_done, bus.collect_busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.drain_done !== 1'b0 || bus.collect_busy !== 1'b0 || bus.misalign !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: got done=%b busy=%b mis=%b expected done=0 busy=0 mis=0",
               bus.drain_done, bus.collect_busy, bus.misalign);
    end
  endtask

  task automatic test_misalign();
    bit ok;
    bus.row_ready = 1'b1;
    @(negedge clk);
    drive(3'b001, 8'd5, 8'd0, 8'd0);
    @(negedge clk);
    drive(3'b001, 8'd6, 8'd0, 8'd0);
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    bus.conv_finish = 1'b1;
    @(negedge clk);
    bus.conv_finish = 1'b0;
    #1;
    checks++;
    if (bus.drain_done !== 1'b1 || bus.misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_flush: got done=%b mis=%b expected done=1 mis=0", bus.drain_done, bus.misalign);
    end
    @(negedge clk);
    drive(3'b111, 8'd7, 8'd8, 8'd9);
    #1;
    checks++;
    if (bus.misalign !== 1'b1 || bus.drain_done !== 1'b0 || bus.collect_busy !== 1'b0 || bus.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_flag: got mis=%b done=%b busy=%b v=%b expected mis=1 done=0 busy=0 v=0",
               bus.misalign, bus.drain_done, bus.collect_busy, bus.row_valid);
    end
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    #1;
    checks++;
    if (bus.misalign !== 1'b0 || bus.row_valid !== 1'b1 || bus.row_data[0] !== 8'd7 ||
        bus.row_data[1] !== 8'd8 || bus.row_data[2] !== 8'd9) begin
      errors++;
      $display("FAIL mis_next_job: got mis=%b v=%b (%0d,%0d,%0d) expected mis=0 v=1 (7,8,9)",
               bus.misalign, bus.row_valid, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.row_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_empty: got valid=%b expected 0", bus.row_valid);
    end
    finish_job(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mis_done: got no drain_done expected drain_done pulse");
    end
  endtask

  task automatic test_reset_mid();
    bus.row_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(3'b111, 8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3));
    end
    @(negedge clk);
    drive(3'b000, 8'd0, 8'd0, 8'd0);
    #1;
    checks++;
    if (bus.row_valid !== 1'b1 || bus.collect_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got v=%b busy=%b expected v=1 busy=1", bus.row_valid, bus.collect_busy);
    end
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.row_valid !== 1'b0 || bus.collect_busy !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.row_data[0] !== 8'd0 || bus.row_data[1] !== 8'd0 || bus.row_data[2] !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b busy=%b ovf=%b (%0d,%0d,%0d) expected all 0",
               bus.row_valid, bus.collect_busy, bus.overflow, bus.row_data[0], bus.row_data[1], bus.row_data[2]);
    end
    @(negedge clk);
    nrst = 1'b1;
    bus.row_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.row_valid !== 1'b0 || bus.collect_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after%0d: got v=%b busy=%b expected v=0 busy=0", s, bus.row_valid, bus.collect_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skewed();
    test_backpressure();
    test_drain();
    test_misalign();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_out_collector.md
Name: systolic_out_collector

Overview:
- Sits downstream of the systolic top and consumes the per-column result stream (systolic_out, out_en, conv_finish).
- Columns emit results diagonally skewed in time. The collector buffers each column in its own FIFO and re-aligns them.
- It presents one full row vector per transfer to the output-buffer writer over a valid/ready handshake.
- On conv_finish it drains the buffered rows and signals job completion.

Parameters:
width, 8, data width per column element (matches array output width)
col, 3, number of array columns (lanes)
depth, 8, per-column FIFO depth in entries; power of 2, >= 2

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
systolic_out  input  width x col (unpacked [col-1:0])  per-column result from array
out_en  input  col  per-column result-valid strobe
conv_finish  input  1  single-cycle pulse: array has produced its last result
row_data  output  width x col (unpacked [col-1:0])  aligned row; element c = head of FIFO c
row_valid  output  1  aligned row available
row_ready  input  1  downstream accepts row_data this cycle
collect_busy  output  1  high in COLLECT and DRAIN
overflow  output  1  sticky: a column push was dropped because its FIFO was full
misalign  output  1  sticky: column counts were unequal at drain end
drain_done  output  1  one-cycle pulse at end of job

Behaviour:
- Reset (nrst=0, async): all FIFO pointers and counts = 0, state = IDLE; every output = 0, including row_data.
- Push, column c:
  - When out_en[c]=1, push systolic_out[c] into FIFO c.
  - A push is accepted if FIFO c is not full, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set.
  - Pushes are honoured in every state, except in the DRAIN flush cycle, where the flush wins.
- Row formation:
  - row_valid = all col FIFOs non-empty; this is combinational from the FIFO counts.
  - row_data = FIFO head entries.
  - Latency: a push at edge t makes that entry visible at t+1. A fully aligned row is visible one cycle after the last column's push.
- Pop: when row_valid && row_ready, all FIFOs pop together. row_data is held stable while row_valid=1 && row_ready=0.
- Simultaneous push and pop on one FIFO: count is unchanged and the data order is preserved.
- State machine (encoded as an enum):
  - IDLE:
    - collect_busy=0.
    - Any out_en bit set -> COLLECT; that cycle's pushes are accepted.
    - conv_finish in IDLE -> DRAIN.
    - On leaving IDLE, overflow and misalign are cleared.
  - COLLECT: conv_finish=1 -> DRAIN.
  - DRAIN: rows continue to be popped normally. Each cycle:
    - All FIFOs empty -> drain_done=1 for that cycle, next state IDLE.
    - Some FIFO empty and some non-empty, with no out_en bit set this cycle -> flush: all pointers reset, misalign=1, drain_done=1, next state IDLE.
- conv_finish arriving while already in DRAIN is ignored.
- Width rules:
  - FIFO pointers are $clog2(depth) bits and wrap modulo depth.
  - The count is $clog2(depth)+1 bits.
  - full = (count==depth); empty = (count==0).
- Reset asserted mid-job: everything returns to reset values immediately; buffered data is lost.

Decomposition:
- Shared package systolic_pkg holds:
  - collector state enum (IDLE, COLLECT, DRAIN);
  - default localparam COLLECT_DEPTH = 8.
- One sub-module, col_fifo (params width, depth):
  - synchronous single-clock FIFO with push, pop, head data, full and empty;
  - async active-low reset;
  - instantiated col times in a generate loop.
- The top holds the FSM, the handshake logic and the sticky flags.

Test Plan:
1. Aligned rows: row_ready=1; out_en=3'b111 for 3 cycles with rows (1,2,3), (4,5,6), (7,8,9) -> row_valid on the next 3 cycles, emitting the same rows in order; overflow=0.
2. Skewed columns: out_en=001 at t0 (data 10), 010 at t1 (data 20), 100 at t2 (data 30) -> row_valid first high at t3 with (10,20,30); low before t3.
3. Backpressure: row_ready=0; 9 aligned rows 1..9 -> 9th row dropped and overflow=1. Then row_ready=1 -> exactly 8 rows out (rows 1..8), row_data stable while stalled.
4. Normal drain: 2 aligned rows buffered, conv_finish pulse, row_ready=1 -> 2 rows emitted, then drain_done pulses one cycle, collect_busy falls, misalign=0.
5. Misalign: out_en=001 twice (col0 only), then conv_finish -> misalign=1, drain_done pulse, all FIFOs empty; next job start clears misalign.
6. Reset mid-COLLECT with 3 entries buffered: nrst low asynchronously between edges -> row_valid, collect_busy, overflow and row_data all 0 immediately; after release, state is IDLE and no rows are emitted.
